// File: rtl/switch_debounce.sv
// Purpose : per-bit two-flop synchroniser + debouncer for raw slide switches,
//           with registered clean levels and one-cycle rise/fall/any pulses.
// Latency : STABLE_CYCLES+2 edges from raw change (incl. sampling edge) to switch_clean.
// Backpressure: none; outputs are sampled every cycle and pulses are not held.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   switch_raw    raw asynchronous switch levels [WIDTH]
//   switch_clean  debounced registered levels [WIDTH]
//   switch_rise   one-cycle pulse when switch_clean[i] goes 0->1
//   switch_fall   one-cycle pulse when switch_clean[i] goes 1->0
//   any_change    OR of all rise/fall bits, same cycle as the pulses
module switch_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch_clean,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall,
  output logic             any_change
);

  localparam int            CW      = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q,  rise_d;
  logic [WIDTH-1:0] fall_q,  fall_d;
  logic             any_q,   any_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Each bit is IDLE when sync2 == clean and PENDING otherwise; the state
  // is fully implied by that comparison, so no separate state flop is kept.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          // Held long enough: commit the new level and fire its edge pulse.
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      // sync2 back at the clean level: a glitch, the count is dropped.
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= switch_raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign switch_clean = clean_q;
  assign switch_rise  = rise_q;
  assign switch_fall  = fall_q;
  assign any_change   = any_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Purpose : self-checking bench for switch_debounce (WIDTH=8, STABLE_CYCLES=4).
// Latency : expected output events are queued with the cycle they are due.
// Backpressure: none; every cycle is checked against the queue or quiet state.
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] switch_raw;
  logic [7:0] switch_clean, switch_rise, switch_fall;
  logic       any_change;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit running = 1'b0;

  typedef struct {
    int         due;
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       any;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_clean = 8'h00;

  switch_debounce #(.WIDTH(8), .STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .switch_raw   (switch_raw),
    .switch_clean (switch_clean),
    .switch_rise  (switch_rise),
    .switch_fall  (switch_fall),
    .any_change   (any_change)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int due, input logic [7:0] c, input logic [7:0] r,
                      input logic [7:0] f, input logic a);
    exp_t e;
    e.due = due; e.clean = c; e.rise = r; e.fall = f; e.any = a;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Monitor: a due event is checked in full, every other cycle must be quiet
  // with switch_clean holding its last expected level.
  always @(negedge clk) begin
    if (running) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("clean_upd", {24'h0, switch_clean}, {24'h0, e.clean});
        chk("rise_upd",  {24'h0, switch_rise},  {24'h0, e.rise});
        chk("fall_upd",  {24'h0, switch_fall},  {24'h0, e.fall});
        chk("any_upd",   {31'h0, any_change},   {31'h0, e.any});
        exp_clean = e.clean;
      end else begin
        chk("clean_hold", {24'h0, switch_clean}, {24'h0, exp_clean});
        chk("rise_quiet", {24'h0, switch_rise},  32'h0);
        chk("fall_quiet", {24'h0, switch_fall},  32'h0);
        chk("any_quiet",  {31'h0, any_change},   32'h0);
      end
    end
  end

  initial begin
    // Reset with all switches high; released level debounces as a real rise.
    rst_n      = 1'b0;
    switch_raw = 8'hFF;
    running    = 1'b1;
    step(5);
    rst_n = 1'b1;
    push(cyc + 6, 8'hFF, 8'hFF, 8'h00, 1'b1);
    step(10);

    // Return everything to 0 (all bits fall together).
    switch_raw = 8'h00;
    push(cyc + 6, 8'h00, 8'h00, 8'hFF, 1'b1);
    step(10);

    // Glitch on bit 3 for 3 cycles: must be rejected.
    switch_raw = 8'h08;
    step(3);
    switch_raw = 8'h00;
    step(12);

    // Bounce bit 0 six times, then settle high.
    for (int i = 0; i < 6; i++) begin
      switch_raw[0] = ~switch_raw[0];
      step(1);
    end
    switch_raw = 8'h01;
    push(cyc + 6, 8'h01, 8'h01, 8'h00, 1'b1);
    step(10);

    // Move to clean 8'h02 (bit 1 rises, bit 0 falls).
    switch_raw = 8'h02;
    push(cyc + 6, 8'h02, 8'h02, 8'h01, 1'b1);
    step(10);

    // Simultaneous rise on bit 7 and fall on bit 1.
    switch_raw = 8'h80;
    push(cyc + 6, 8'h80, 8'h80, 8'h02, 1'b1);
    step(10);

    switch_raw = 8'h00;
    push(cyc + 6, 8'h00, 8'h00, 8'h80, 1'b1);
    step(10);

    // Reset mid-count on bit 5: the count is abandoned and restarts after release.
    switch_raw = 8'h20;
    step(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    push(cyc + 6, 8'h20, 8'h20, 8'h00, 1'b1);
    step(10);

    running = 1'b0;
    chk("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
